i2c_arbiter: RTL and testbench

Round-robin arbiter that shares the single I2C byte engine (the `i2c` block) between `NREQ` requesters, for example the ROM-driven init sequencer and a runtime register/EDID access port. It latches one requester's transaction, issues it to the engine with a one-cycle send pulse, and tracks the engine's ready handshake to completion. It then returns a completion pulse, or an error pulse on timeout or an illegal length, to the owning requester. The arbiter sits between the requesters and the `i2c` instance; `scl_o`/`sda_io` stay on the engine.

---
 rtl/i2c_arbiter.sv | 114 +++++++++++
 tb/tb_i2c_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin arbiter sharing one I2C byte engine between NREQ requesters,
// with send strobe, ready-handshake tracking, timeout and illegal-length error reporting.
module i2c_arbiter #(
    parameter int NREQ    = 2,
    parameter int NBYTES  = 3,
    parameter int NBW     = $clog2(NBYTES + 1),
    parameter int TIMEOUT = 2_000_000
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [NREQ-1:0]            req_i,
    input  logic [NREQ*NBW-1:0]        nbytes_i,
    input  logic [NREQ*NBYTES*8-1:0]   data_i,
    output logic [NREQ-1:0]            grant_o,
    output logic [NREQ-1:0]            done_o,
    output logic [NREQ-1:0]            err_o,
    output logic                       busy_o,
    output logic                       eng_send_o,
    output logic [NBW-1:0]             eng_nbytes_o,
    output logic [NBYTES*8-1:0]        eng_data_o,
    input  logic                       eng_ready_i
);
    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, RELEASE} state_t;

    state_t                 state_q;
    logic [IW-1:0]          ptr_q;
    logic [IW-1:0]          gidx_q;
    logic [TW-1:0]          timer_q;
    logic                   err_q;
    logic [NREQ-1:0]        grant_q;
    logic [NBW-1:0]         nbytes_q;
    logic [NBYTES*8-1:0]    data_q;
    logic [IW-1:0]          win_idx;
    logic                   win_vld;
    logic [NBW-1:0]         win_nb;
    int                     j;

    // Scan downward so the lowest offset from ptr is the last (winning) assignment.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        j = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req_i[IW'(j)]) begin
                win_vld = 1'b1;
                win_idx = IW'(j);
            end
        end
        win_nb = nbytes_i[int'(win_idx)*NBW +: NBW];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            timer_q  <= '0;
            err_q    <= 1'b0;
            grant_q  <= '0;
            nbytes_q <= '0;
            data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (win_vld && eng_ready_i) begin
                    grant_q  <= NREQ'(1) << win_idx;
                    gidx_q   <= win_idx;
                    nbytes_q <= win_nb;
                    data_q   <= data_i[int'(win_idx)*NBYTES*8 +: NBYTES*8];
                    if (win_nb == '0 || win_nb > NBW'(NBYTES)) begin
                        err_q   <= 1'b1;
                        state_q <= RELEASE;
                    end else begin
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                    state_q <= WAIT_LO;
                end
                WAIT_LO, WAIT_HI: begin
                    if (timer_q != TW'(TIMEOUT)) timer_q <= timer_q + TW'(1);
                    if (timer_q == TW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= RELEASE;
                    end else if (state_q == WAIT_LO && !eng_ready_i) begin
                        state_q <= WAIT_HI;
                    end else if (state_q == WAIT_HI && eng_ready_i) begin
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    ptr_q   <= (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
                    grant_q <= '0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o      = grant_q;
    assign done_o       = (state_q == RELEASE) ? grant_q : '0;
    assign err_o        = done_o & {NREQ{err_q}};
    assign busy_o       = state_q != IDLE;
    assign eng_send_o   = state_q == ISSUE;
    assign eng_nbytes_o = nbytes_q;
    assign eng_data_o   = data_q;
endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: table-driven transactions against an engine model, plus timeout
// and mid-transaction reset sequences.
module tb_i2c_arbiter;
    typedef struct {
        logic [1:0]  req;
        logic [1:0]  nb0, nb1;
        logic [23:0] d0, d1;
        int          lat;
        bit          drop;
        logic [1:0]  g;
        bit          e;
        int          sends;
        int          dl;
        logic [1:0]  enb;
        logic [23:0] ed;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_i = '0;
    logic [3:0]  nbytes_i = '0;
    logic [47:0] data_i = '0;
    logic [1:0]  grant_o, done_o, err_o;
    logic        busy_o, eng_send_o;
    logic [1:0]  eng_nbytes_o;
    logic [23:0] eng_data_o;
    logic        eng_ready;
    int          lat = 30, cnt, sends = 0, cyc = 0, n_chk = 0, n_bad = 0;
    bit          hang = 0;
    vec_t        v[8];

    i2c_arbiter #(.NREQ(2), .NBYTES(3), .TIMEOUT(50)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req_i), .nbytes_i(nbytes_i), .data_i(data_i),
        .grant_o(grant_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
        .eng_send_o(eng_send_o), .eng_nbytes_o(eng_nbytes_o), .eng_data_o(eng_data_o),
        .eng_ready_i(eng_ready)
    );

    always #5 clk = ~clk;

    // Engine: drops ready the cycle after a send, re-raises it lat cycles later unless hung.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_ready <= 1'b1;
            cnt       <= 0;
        end else if (eng_send_o) begin
            eng_ready <= 1'b0;
            cnt       <= lat;
        end else if (!eng_ready && !hang) begin
            if (cnt <= 1) eng_ready <= 1'b1;
            else cnt <= cnt - 1;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (eng_send_o) sends <= sends + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input int n, input vec_t t);
        int g, s0, i;
        req_i    = t.req;
        nbytes_i = {t.nb1, t.nb0};
        data_i   = {t.d1, t.d0};
        lat      = t.lat;
        s0       = sends;
        i        = 0;
        do begin
            @(negedge clk);
            i++;
        end while (grant_o == '0 && i < 20);
        chk($sformatf("v%0d grant", n), 64'(grant_o), 64'(t.g));
        if (grant_o == '0) return;
        g = cyc;
        chk($sformatf("v%0d nbytes", n), 64'(eng_nbytes_o), 64'(t.enb));
        chk($sformatf("v%0d data", n), 64'(eng_data_o), 64'(t.ed));
        i = 0;
        while (done_o == '0 && i < 200) begin
            @(negedge clk);
            i++;
            if (t.drop) req_i = '0;
        end
        chk($sformatf("v%0d done", n), 64'(done_o), 64'(t.g));
        chk($sformatf("v%0d err", n), 64'(err_o), 64'(t.e ? t.g : 2'b00));
        chk($sformatf("v%0d latency", n), 64'(cyc - g), 64'(t.dl));
        chk($sformatf("v%0d sends", n), 64'(sends - s0), 64'(t.sends));
        chk($sformatf("v%0d data_stable", n), 64'(eng_data_o), 64'(t.ed));
        @(negedge clk);
        chk($sformatf("v%0d idle", n), 64'({busy_o, grant_o, done_o}), 64'(0));
    endtask

    initial begin
        int g, i;
        bit bad;
        v[0] = '{req:2'b01, nb0:2'd3, nb1:2'd0, d0:24'h720835, d1:24'h0, lat:30, drop:0,
                 g:2'b01, e:0, sends:1, dl:32, enb:2'd3, ed:24'h720835};
        v[1] = '{req:2'b11, nb0:2'd3, nb1:2'd3, d0:24'h111111, d1:24'h222222, lat:1, drop:0,
                 g:2'b10, e:0, sends:1, dl:3, enb:2'd3, ed:24'h222222};
        v[2] = '{req:2'b11, nb0:2'd3, nb1:2'd3, d0:24'h111111, d1:24'h222222, lat:1, drop:0,
                 g:2'b01, e:0, sends:1, dl:3, enb:2'd3, ed:24'h111111};
        v[3] = v[1];
        v[4] = v[2];
        v[5] = '{req:2'b10, nb0:2'd3, nb1:2'd0, d0:24'h0, d1:24'habcdef, lat:5, drop:0,
                 g:2'b10, e:1, sends:0, dl:0, enb:2'd0, ed:24'habcdef};
        v[6] = '{req:2'b01, nb0:2'd2, nb1:2'd0, d0:24'h0000c3, d1:24'h0, lat:5, drop:1,
                 g:2'b01, e:0, sends:1, dl:7, enb:2'd2, ed:24'h0000c3};
        v[7] = '{req:2'b11, nb0:2'd1, nb1:2'd2, d0:24'h000055, d1:24'h00aa77, lat:4, drop:0,
                 g:2'b10, e:0, sends:1, dl:6, enb:2'd2, ed:24'h00aa77};

        repeat (2) @(negedge clk);
        chk("reset outputs", 64'({grant_o, done_o, err_o, busy_o, eng_send_o, eng_nbytes_o, eng_data_o}), 64'(0));
        rst_n = 1'b1;

        for (int n = 0; n < 8; n++) run_txn(n, v[n]);

        // Timeout: engine never comes back, then blocks arbitration until it does.
        req_i    = 2'b01;
        nbytes_i = 4'b0011;
        data_i   = 48'h0000_0012_3456;
        lat      = 30;
        hang     = 1;
        i        = 0;
        do begin
            @(negedge clk);
            i++;
        end while (grant_o == '0 && i < 20);
        chk("to grant", 64'(grant_o), 64'(2'b01));
        g = cyc;
        i = 0;
        while (done_o == '0 && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("to latency", 64'(cyc - g), 64'(51));
        chk("to done", 64'(done_o), 64'(2'b01));
        chk("to err", 64'(err_o), 64'(2'b01));
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (grant_o != '0 || busy_o) bad = 1;
        end
        chk("to no regrant while engine busy", 64'(bad), 64'(0));
        hang = 0;
        i    = 0;
        while (grant_o == '0 && i < 60) begin
            @(negedge clk);
            i++;
        end
        chk("to regrant after ready", 64'(grant_o), 64'(2'b01));

        // Reset in WAIT_HI: outputs clear at once and ptr returns to 0.
        repeat (10) @(negedge clk);
        chk("pre-reset busy", 64'(busy_o), 64'(1));
        #2 rst_n = 1'b0;
        #1 chk("async reset outputs",
               64'({grant_o, done_o, err_o, busy_o, eng_send_o, eng_nbytes_o, eng_data_o}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        req_i = 2'b11;
        i     = 0;
        do begin
            @(negedge clk);
            i++;
        end while (grant_o == '0 && i < 20);
        chk("post-reset ptr", 64'(grant_o), 64'(2'b01));

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
